// File: rtl/uart_receiver.sv
// uart_receiver: 16x oversampling UART receive stage feeding the display data bus.
// Frames start + 8 data bits (LSB first) + optional even parity + stop.
// Optional feature macro: UART_PARITY_EN (8E1 frame, live Rx_PERROR); default is 8N1.
module uart_receiver #(
  parameter int unsigned SAMPLE_DIV = 54
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  input  logic       Rx_EN,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_FERROR,
  output logic       Rx_PERROR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [1:0]  sync;
  logic        rxs;
  logic [15:0] tick_cnt;
  logic        tick;
  logic [3:0]  samp_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;

  logic        tick_clr;
  logic        samp_clr;
  logic        bit_clr;
  logic        shift_en;
  logic        load;
  logic        set_ferr;
  logic        clr_flags;
`ifdef UART_PARITY_EN
  logic        par_cap;
  logic        par_bad;
  logic        set_perr;
`endif

  assign rxs  = sync[1];
  assign tick = (tick_cnt == 16'(SAMPLE_DIV - 1));

  // Two-flop synchronizer on the serial line; idles high out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= '1;
    else        sync <= {sync[0], RxD};
  end

  // Oversample tick divider, realigned to the accepted start edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        tick_cnt <= '0;
    else if (tick_clr) tick_cnt <= '0;
    else if (tick)     tick_cnt <= '0;
    else               tick_cnt <= tick_cnt + 16'd1;
  end

  // Sample (tick) counter and bit counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (samp_clr)  samp_cnt <= '0;
      else if (tick) samp_cnt <= samp_cnt + 4'd1;
      if (bit_clr)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state and datapath strobes
  always_comb begin
    state_next = state;
    tick_clr   = 1'b0;
    samp_clr   = 1'b0;
    bit_clr    = 1'b0;
    shift_en   = 1'b0;
    load       = 1'b0;
    set_ferr   = 1'b0;
    clr_flags  = 1'b0;
`ifdef UART_PARITY_EN
    par_cap    = 1'b0;
    set_perr   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (Rx_EN && !rxs) begin
          state_next = S_START;
          tick_clr   = 1'b1;
          samp_clr   = 1'b1;
          bit_clr    = 1'b1;
          clr_flags  = 1'b1;
        end
      end
      S_START: begin
        if (tick && samp_cnt == 4'd7) begin
          if (!rxs) begin
            state_next = S_DATA;
            samp_clr   = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick && samp_cnt == 4'd15) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (tick && samp_cnt == 4'd15) begin
          par_cap    = 1'b1;
          state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick && samp_cnt == 4'd15) begin
          if (rxs) begin
`ifdef UART_PARITY_EN
            if (par_bad) set_perr = 1'b1;
            else         load     = 1'b1;
`else
            load = 1'b1;
`endif
            state_next = S_IDLE;
          end else begin
            set_ferr   = 1'b1;
            state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxs) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Receive shift register, LSB first
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        shreg <= '0;
    else if (shift_en) shreg <= {rxs, shreg[7:1]};
  end

`ifdef UART_PARITY_EN
  // Even-parity check against the sampled parity bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       par_bad <= 1'b0;
    else if (par_cap) par_bad <= (rxs != ^shreg);
  end

  // Sticky parity error flag, cleared when the next start is accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         Rx_PERROR <= 1'b0;
    else if (clr_flags) Rx_PERROR <= 1'b0;
    else if (set_perr)  Rx_PERROR <= 1'b1;
  end
`else
  assign Rx_PERROR = 1'b0;
`endif

  // Output byte register and one-cycle valid pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Rx_DATA  <= '0;
      Rx_VALID <= 1'b0;
    end else begin
      Rx_VALID <= load;
      if (load) Rx_DATA <= shreg;
    end
  end

  // Sticky framing error flag, cleared when the next start is accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         Rx_FERROR <= 1'b0;
    else if (clr_flags) Rx_FERROR <= 1'b0;
    else if (set_ferr)  Rx_FERROR <= 1'b1;
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed + randomized frames against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int unsigned DIV    = 4;
  localparam int unsigned BIT    = 16 * DIV;
  localparam int unsigned CLK_NS = 10;
`ifdef UART_PARITY_EN
  localparam bit          PAR_EN     = 1'b1;
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam bit          PAR_EN     = 1'b0;
  localparam int unsigned FRAME_BITS = 10;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       RxD   = 1'b1;
  logic       Rx_EN = 1'b0;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_FERROR;
  logic       Rx_PERROR;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  logic [7:0] got_q[$];
  time        got_t[$];

  // Reference model: what the display should show and the sticky flags
  logic [7:0] m_data;
  logic       m_ferr;
  logic       m_perr;

  uart_receiver #(.SAMPLE_DIV(DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .RxD      (RxD),
    .Rx_EN    (Rx_EN),
    .Rx_DATA  (Rx_DATA),
    .Rx_VALID (Rx_VALID),
    .Rx_FERROR(Rx_FERROR),
    .Rx_PERROR(Rx_PERROR)
  );

  always #(CLK_NS / 2) clk = ~clk;

  // Record every valid pulse (one entry per high cycle)
  always @(negedge clk) begin
    if (Rx_VALID === 1'b1) begin
      got_q.push_back(Rx_DATA);
      got_t.push_back($time);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic hold(input logic v, input int unsigned n);
    RxD = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_head();
    hold(1'b0, 8);
  endtask

  task automatic frame_tail(input logic [7:0] d, input logic stop, input logic bad_par);
    hold(1'b0, BIT - 8);
    for (int i = 0; i < 8; i++) hold(d[i], BIT);
    if (PAR_EN) hold((^d) ^ bad_par, BIT);
    hold(stop, BIT);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par);
    frame_head();
    frame_tail(d, stop, bad_par);
  endtask

  // Frame outcome from the protocol rules
  task automatic model_frame(input logic [7:0] d, input logic stop, input logic bad_par,
                             output int unsigned exp_pulses);
    m_ferr     = 1'b0;
    m_perr     = 1'b0;
    exp_pulses = 0;
    if (!stop)                  m_ferr = 1'b1;
    else if (PAR_EN && bad_par) m_perr = 1'b1;
    else begin
      m_data     = d;
      exp_pulses = 1;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".data"},  {24'd0, Rx_DATA}, {24'd0, m_data});
    check({tag, ".ferr"},  {31'd0, Rx_FERROR}, {31'd0, m_ferr});
    check({tag, ".perr"},  {31'd0, Rx_PERROR}, {31'd0, m_perr});
    check({tag, ".valid"}, {31'd0, Rx_VALID}, 32'd0);
  endtask

  task automatic frame_and_check(input string tag, input logic [7:0] d, input logic stop,
                                 input logic bad_par);
    int unsigned base;
    int unsigned ep;
    base = got_q.size();
    model_frame(d, stop, bad_par, ep);
    send_frame(d, stop, bad_par);
    if (!stop) begin
      hold(1'b0, 3 * BIT);
      hold(1'b1, BIT);
    end else begin
      hold(1'b1, 16);
    end
    check({tag, ".pulses"}, got_q.size() - base, ep);
    if (ep == 1 && got_q.size() == base + 1)
      check({tag, ".pulse_data"}, {24'd0, got_q[base]}, {24'd0, d});
    check_outputs(tag);
  endtask

  initial begin
    int unsigned base;
    logic [7:0]  d;
    logic        stop;
    logic        bad;

    // Reset values
    reset = 1'b0;
    Rx_EN = 1'b1;
    RxD   = 1'b1;
    repeat (5) @(negedge clk);
    m_data = 8'h00;
    m_ferr = 1'b0;
    m_perr = 1'b0;
    check_outputs("reset");
    reset = 1'b1;
    hold(1'b1, BIT);

    // Framing error, held-low break, recovery on the next frame
    base = got_q.size();
    send_frame(8'h12, 1'b0, 1'b0);
    hold(1'b0, 3 * BIT);
    check("ferr.set",    {31'd0, Rx_FERROR}, 32'd1);
    check("ferr.data",   {24'd0, Rx_DATA}, 32'h00);
    check("ferr.pulses", got_q.size() - base, 32'd0);
    hold(1'b1, BIT);
    check("ferr.sticky", {31'd0, Rx_FERROR}, 32'd1);
    frame_head();
    check("ferr.clear",  {31'd0, Rx_FERROR}, 32'd0);
    frame_tail(8'h34, 1'b1, 1'b0);
    hold(1'b1, 16);
    m_data = 8'h34;
    m_ferr = 1'b0;
    m_perr = 1'b0;
    check("ferr.next_pulses", got_q.size() - base, 32'd1);
    check_outputs("ferr.next");

    // Basic good frame
    frame_and_check("a5", 8'hA5, 1'b1, 1'b0);

    // Back-to-back frames with no idle gap
    base = got_q.size();
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    hold(1'b1, 16);
    m_data = 8'hFF;
    check("b2b.pulses", got_q.size() - base, 32'd2);
    if (got_q.size() == base + 2) begin
      check("b2b.first",  {24'd0, got_q[base]}, 32'h3C);
      check("b2b.second", {24'd0, got_q[base + 1]}, 32'hFF);
      check("b2b.spacing", 32'(got_t[base + 1] - got_t[base]), FRAME_BITS * BIT * CLK_NS);
    end
    check_outputs("b2b");

    // Short low glitch is a false start
    base = got_q.size();
    hold(1'b0, 20);
    hold(1'b1, 2 * BIT);
    check("glitch.pulses", got_q.size() - base, 32'd0);
    check_outputs("glitch");

`ifdef UART_PARITY_EN
    // Parity bit 0 with an odd-weight byte
    frame_and_check("perr", 8'h01, 1'b1, 1'b1);
    frame_and_check("perr.recover", 8'h81, 1'b1, 1'b0);
`endif

    // Enable dropped mid-frame: the frame still completes
    base = got_q.size();
    frame_head();
    Rx_EN = 1'b0;
    frame_tail(8'h6E, 1'b1, 1'b0);
    hold(1'b1, 16);
    m_data = 8'h6E;
    m_ferr = 1'b0;
    m_perr = 1'b0;
    check("en_mid.pulses", got_q.size() - base, 32'd1);
    check_outputs("en_mid");

    // Enable low: new start is ignored
    base = got_q.size();
    send_frame(8'h99, 1'b1, 1'b0);
    hold(1'b1, 16);
    check("en_off.pulses", got_q.size() - base, 32'd0);
    check_outputs("en_off");
    Rx_EN = 1'b1;

    // Reset three bit periods into a frame
    base = got_q.size();
    frame_head();
    hold(1'b0, BIT - 8);
    hold(1'b1, BIT);
    hold(1'b0, BIT);
    reset = 1'b0;
    #1;
    m_data = 8'h00;
    m_ferr = 1'b0;
    m_perr = 1'b0;
    check_outputs("midreset");
    RxD = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    hold(1'b1, BIT);
    check("midreset.pulses", got_q.size() - base, 32'd0);
    frame_and_check("after_reset", 8'h5A, 1'b1, 1'b0);

    // Randomized frames
    for (int k = 0; k < 12; k++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      bad  = PAR_EN && ($urandom_range(0, 2) == 0);
      frame_and_check("rand", d, stop, bad);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

UART receive stage for the 7-segment display path: it oversamples the serial line at 16x the baud rate and frames start, 8 data bits, an optional parity bit and a stop bit. It delivers each correctly received byte on a parallel bus that feeds the four-digit LED driver's 8-bit data input. Frames with errors are flagged and never overwrite the displayed byte.

## Interface
- SAMPLE_DIV, 54: clk cycles per oversample tick (1/16 bit). 54 gives ≈115200 baud at 100 MHz. Legal range 2..65535.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- RxD  input  1  serial line; idles high.
- Rx_EN  input  1  receiver enable; gates only new start-bit detection.
- Rx_DATA  output  8  last good byte; drives the display data input.
- Rx_VALID  output  1  one-cycle pulse when Rx_DATA is updated.
- Rx_FERROR  output  1  framing error flag (stop bit sampled 0).
- Rx_PERROR  output  1  parity error flag; constant 0 without UART_PARITY_EN.

## Operation
- RxD passes through a 2-flop synchronizer. Both flops reset to 1. Only the synchronized value rxs is used.
- Tick generator: 16-bit counter counting 0..SAMPLE_DIV-1. It emits tick for one cycle at SAMPLE_DIV-1, then wraps to 0. It is cleared on leaving IDLE so sampling aligns to the detected start edge.
- Sample counter: 4 bits, counts ticks. Bit counter: 3 bits.
- FSM states and transitions:
  - IDLE: if Rx_EN and rxs==0, go to START and clear both counters.
  - START: at the 8th tick (mid-bit), re-check rxs. If rxs==0, go to DATA and clear the sample counter. If rxs==1, treat as a false start and return to IDLE with no flags.
  - DATA: every 16th tick, shift rxs into the shift register LSB first. After bit 7, go to PARITY (if compiled in) or STOP.
  - PARITY: at the 16th tick, sample the parity bit and compare with even parity of the shifted byte.
  - STOP: at the 16th tick, sample the stop bit.
    - If stop==1 and parity is OK: Rx_DATA <= shift register, pulse Rx_VALID, go to IDLE.
    - If stop==1 and parity is bad: set Rx_PERROR, Rx_DATA unchanged, go to IDLE.
    - If stop==0: set Rx_FERROR, Rx_DATA unchanged, go to BREAK.
  - BREAK: wait for rxs==1, then go to IDLE. This prevents a held-low line from retriggering.
- Rx_FERROR and Rx_PERROR are sticky. Both clear in the cycle IDLE accepts the next start edge.
- Rx_EN deasserted mid-frame: the current frame completes normally. Only the next start is blocked.

## Timing
- Reset values: Rx_DATA=8'h00, Rx_VALID=0, Rx_FERROR=0, Rx_PERROR=0, FSM=IDLE, counters=0, synchronizer=2'b11. Display shows 00 after reset.
- Start-detect latency: 2 clk cycles (synchronizer) after the RxD falling edge.
- Rx_VALID, Rx_DATA and the error flags update on the clk edge following the stop-bit mid-sample tick, all in the same cycle.
- End of frame to IDLE: immediate. Back-to-back frames with no idle gap are received.
- One bit period is 16*SAMPLE_DIV clk cycles. Data is sampled at bit centres (8 + 16k ticks from the start edge).
- A reset assertion mid-frame returns everything to reset values immediately (asynchronous). The partial byte is discarded.

## Configuration
- UART_PARITY_EN defined:
  - Frame is 8E1. The PARITY state exists and expects even parity.
  - Rx_PERROR is live.
- Not defined:
  - Frame is 8N1 and the PARITY state is removed.
  - Rx_PERROR is tied to 0.

## Test plan
- SAMPLE_DIV=4 (64 clk per bit). Send 8'hA5 with a valid stop bit (and even parity bit 0 under the macro) -> Rx_VALID pulses once; Rx_DATA=8'hA5; both flags 0.
- Send 8'h3C then 8'hFF back-to-back, no idle gap -> two Rx_VALID pulses exactly 10 (or 11) bit periods apart; Rx_DATA ends at 8'hFF.
- Send 8'h12 with stop bit 0, hold RxD low 3 bit periods, then send 8'h34 -> Rx_FERROR=1 and Rx_DATA stays 8'h00 with no pulse; FERROR clears at the 8'h34 start; Rx_DATA=8'h34.
- Under UART_PARITY_EN, send 8'h01 with parity bit 0 -> Rx_PERROR=1, no Rx_VALID, Rx_DATA unchanged.
- Drive a 20-clk low glitch on RxD -> false start; FSM returns to IDLE; no outputs change.
- Assert reset 3 bit periods into a frame, then release and send 8'h5A -> outputs return to reset values; only 8'h5A is received.
